// File: rtl/manchester_frame_encoder.sv
`default_nettype none
// ============================================================================
// Module   : manchester_frame_encoder
// Purpose  : Frames a bit stream as SOF + data + EOF Manchester symbols,
//            optionally gated by a phase-locked subcarrier.
// Revision : 1.0 - initial release
// ============================================================================
module manchester_frame_encoder #(
  parameter int BIT_TICKS        = 128,
  parameter int SUBCARRIER_TICKS = 16,
  parameter bit MODULATE         = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic in_data,
  input  logic in_data_valid,
  output logic in_req,
  output logic encoded_data,
  output logic last_tick,
  output logic done
);

  localparam int TW = $clog2(BIT_TICKS);
  localparam int SW = $clog2(SUBCARRIER_TICKS);

  localparam logic [TW-1:0] c_tick_last = TW'(BIT_TICKS - 1);
  localparam logic [TW-1:0] c_tick_half = TW'(BIT_TICKS / 2);
  localparam logic [SW-1:0] c_sc_last   = SW'(SUBCARRIER_TICKS - 1);
  localparam logic [SW-1:0] c_sc_half   = SW'(SUBCARRIER_TICKS / 2);

  localparam logic [2:0] c_idle = 3'd0;
  localparam logic [2:0] c_sof  = 3'd1;
  localparam logic [2:0] c_data = 3'd2;
  localparam logic [2:0] c_eof  = 3'd3;
  localparam logic [2:0] c_done = 3'd4;

  logic [2:0]    r_state;
  logic [TW-1:0] r_tick;
  logic [SW-1:0] r_sc;
  logic          r_bit;
  logic          r_next_bit;
  logic          r_next_valid;

  logic [2:0]    w_state;
  logic [TW-1:0] w_tick;
  logic [SW-1:0] w_sc;
  logic          w_bit;
  logic          w_sym;
  logic          w_active;
  logic          w_sym_bit;
  logic          w_level;
  logic          w_sc_on;
  logic          w_enc;

  // Next-state values describe the tick that will be on the outputs after
  // this edge, so every registered output is aligned with encoded_data.
  always_comb begin
    w_state = r_state;
    w_tick  = r_tick;
    w_bit   = r_bit;
    case (r_state)
      c_idle: begin
        if (en) begin
          w_state = c_sof;
          w_tick  = '0;
        end
      end
      c_sof, c_data: begin
        if (r_tick == c_tick_last) begin
          w_state = r_next_valid ? c_data : c_eof;
          w_bit   = r_next_bit;
          w_tick  = '0;
        end else begin
          w_tick = r_tick + TW'(1);
        end
      end
      c_eof: begin
        if (r_tick == c_tick_last) begin
          w_state = c_done;
          w_tick  = '0;
        end else begin
          w_tick = r_tick + TW'(1);
        end
      end
      c_done:  w_state = c_done;
      default: begin
        w_state = c_idle;
        w_tick  = '0;
      end
    endcase
    if (!en) begin
      w_state = c_idle;
      w_tick  = '0;
    end
  end

  // Subcarrier phase restarts with every bit period.
  always_comb begin
    w_sc = '0;
    if (w_tick != '0) begin
      w_sc = (r_sc == c_sc_last) ? '0 : r_sc + SW'(1);
    end
  end

  always_comb begin
    w_sym     = (w_state == c_sof) || (w_state == c_data);
    w_active  = w_sym || (w_state == c_eof);
    w_sym_bit = (w_state == c_sof) ? 1'b1 : w_bit;
    w_level   = w_sym && ((w_tick < c_tick_half) ? w_sym_bit : !w_sym_bit);
    w_sc_on   = (w_sc < c_sc_half);
    w_enc     = MODULATE ? (w_level && w_sc_on) : w_level;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= c_idle;
      r_tick       <= '0;
      r_sc         <= '0;
      r_bit        <= 1'b0;
      r_next_bit   <= 1'b0;
      r_next_valid <= 1'b0;
      in_req       <= 1'b0;
      last_tick    <= 1'b0;
      done         <= 1'b0;
      encoded_data <= 1'b0;
    end else begin
      r_state <= w_state;
      r_tick  <= w_tick;
      r_sc    <= w_sc;
      r_bit   <= w_bit;
      if (in_req) begin
        r_next_bit   <= in_data;
        r_next_valid <= in_data_valid;
      end
      in_req       <= w_sym && (w_tick == c_tick_half);
      last_tick    <= w_active && (w_tick == c_tick_last);
      done         <= (w_state == c_eof) && (w_tick == c_tick_last);
      encoded_data <= w_enc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_manchester_frame_encoder.sv
`default_nettype none
// Bench for manchester_frame_encoder: directed frame table, abort/reset
// sequences and random frames against a period-level reference model.
module tb_manchester_frame_encoder;

  logic clk = 1'b0;
  logic rst;
  logic en_a, d_a, v_a;
  logic en_b, d_b, v_b;
  logic req0, enc0, lt0, dn0;
  logic req1, enc1, lt1, dn1;
  logic req2, enc2, lt2, dn2;

  int total = 0;
  int bad   = 0;

  logic [63:0] tx_bits;
  logic        cap_a0 [0:4095];
  logic        cap_a1 [0:4095];
  logic        cap_b  [0:4095];

  always #5 clk = ~clk;

  manchester_frame_encoder #(.BIT_TICKS(128), .SUBCARRIER_TICKS(16), .MODULATE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .en(en_a), .in_data(d_a), .in_data_valid(v_a),
    .in_req(req0), .encoded_data(enc0), .last_tick(lt0), .done(dn0));

  manchester_frame_encoder #(.BIT_TICKS(128), .SUBCARRIER_TICKS(16), .MODULATE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .en(en_a), .in_data(d_a), .in_data_valid(v_a),
    .in_req(req1), .encoded_data(enc1), .last_tick(lt1), .done(dn1));

  manchester_frame_encoder #(.BIT_TICKS(32), .SUBCARRIER_TICKS(8), .MODULATE(1'b1)) dut2 (
    .clk(clk), .rst(rst), .en(en_b), .in_data(d_b), .in_data_valid(v_b),
    .in_req(req2), .encoded_data(enc2), .last_tick(lt2), .done(dn2));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Expected {encoded_data, in_req, last_tick, done} for display cycle k of a
  // frame of n bits, k = 0 being the cycle showing SOF tick 0.
  function automatic logic [3:0] model(input int bt, input int scp, input bit md,
                                       input int n, input int k);
    int p, t;
    logic b, lvl, sc;
    if (k < 0 || k >= (n + 2) * bt) return 4'b0000;
    p = k / bt;
    t = k % bt;
    b = 1'b1;
    if (p >= 1 && p <= n) b = tx_bits[6'(p - 1)];
    lvl = (p <= n) ? ((t < bt / 2) ? b : ~b) : 1'b0;
    sc  = ((t % scp) < scp / 2);
    return {md ? (lvl & sc) : lvl, (p <= n) && (t == bt / 2), (t == bt - 1),
            (p == n + 1) && (t == bt - 1)};
  endfunction

  task automatic run_frame(input bit side_b, input int n, output int done_k, output int reqs);
    int bt, scp, req_i;
    bt = side_b ? 32 : 128;
    scp = side_b ? 8 : 16;
    req_i = 0;
    done_k = -1;
    reqs = 0;
    @(posedge clk); #1;
    if (side_b) begin en_b = 1'b1; v_b = 1'b0; d_b = 1'b0; end
    else        begin en_a = 1'b1; v_a = 1'b0; d_a = 1'b0; end
    @(posedge clk);
    for (int k = 0; k < (n + 2) * bt + 4; k++) begin
      @(negedge clk);
      if (side_b) begin
        chk($sformatf("b_n%0d_k%0d", n, k), {28'd0, enc2, req2, lt2, dn2},
            {28'd0, model(bt, scp, 1'b1, n, k)});
        if (k < 4096) cap_b[k] = enc2;
        if (dn2 && done_k < 0) done_k = k;
        if (req2) begin
          reqs++;
          if (req_i < 64) d_b = tx_bits[6'(req_i)];
          v_b = (req_i < n);
          req_i++;
        end
      end else begin
        chk($sformatf("a0_n%0d_k%0d", n, k), {28'd0, enc0, req0, lt0, dn0},
            {28'd0, model(bt, scp, 1'b0, n, k)});
        chk($sformatf("a1_n%0d_k%0d", n, k), {28'd0, enc1, req1, lt1, dn1},
            {28'd0, model(bt, scp, 1'b1, n, k)});
        if (k < 4096) begin cap_a0[k] = enc0; cap_a1[k] = enc1; end
        if (dn0 && done_k < 0) done_k = k;
        if (req0) begin
          reqs++;
          if (req_i < 64) d_a = tx_bits[6'(req_i)];
          v_a = (req_i < n);
          req_i++;
        end
      end
    end
    if (side_b) en_b = 1'b0; else en_a = 1'b0;
    @(negedge clk);
    chk("idle_after_frame", {20'd0, enc0, req0, lt0, dn0, enc1, req1, lt1, dn1, enc2, req2, lt2, dn2}, 32'd0);
  endtask

  typedef struct {
    bit         side_b;
    int         n;
    logic [7:0] bits;
    int         exp_done;
    int         exp_reqs;
    int         pk;
    logic       exp_e0;
    logic       exp_e1;
  } vec_t;

  initial begin
    vec_t vecs [5];
    int dk, rq, n, saw_done;

    // bits[i] is the i-th data bit sent; exp_e0 is dut0 (or dut2), exp_e1 dut1
    vecs[0] = '{1'b0, 1, 8'b0000_0000, 383, 2, 200, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1, 8'b0000_0001, 383, 2, 131, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 0, 8'b0000_0000, 255, 1, 140, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 2, 8'b0000_0001, 127, 3,  81, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 3, 8'b0000_0101, 639, 4, 394, 1'b1, 1'b0};

    rst = 1'b1;
    en_a = 1'b1; d_a = 1'b1; v_a = 1'b1;
    en_b = 1'b1; d_b = 1'b1; v_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {20'd0, enc0, req0, lt0, dn0, enc1, req1, lt1, dn1, enc2, req2, lt2, dn2}, 32'd0);
    en_a = 1'b0; en_b = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      tx_bits = {56'd0, vecs[i].bits};
      run_frame(vecs[i].side_b, vecs[i].n, dk, rq);
      chk($sformatf("vec%0d_done_k", i), dk, vecs[i].exp_done);
      chk($sformatf("vec%0d_reqs", i), rq, vecs[i].exp_reqs);
      if (vecs[i].side_b) begin
        chk($sformatf("vec%0d_probe", i), {31'd0, cap_b[vecs[i].pk]}, {31'd0, vecs[i].exp_e0});
      end else begin
        chk($sformatf("vec%0d_probe0", i), {31'd0, cap_a0[vecs[i].pk]}, {31'd0, vecs[i].exp_e0});
        chk($sformatf("vec%0d_probe1", i), {31'd0, cap_a1[vecs[i].pk]}, {31'd0, vecs[i].exp_e1});
      end
    end

    // Abort with en low at data tick 40
    @(posedge clk); #1;
    en_a = 1'b1; d_a = 1'b1; v_a = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 168; k++) @(negedge clk);
    chk("abort_pre_level", {31'd0, enc0}, 32'd1);
    en_a = 1'b0;
    saw_done = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (dn0 || dn1) saw_done = 1;
      chk($sformatf("abort_zero_%0d", k), {24'd0, enc0, req0, lt0, dn0, enc1, req1, lt1, dn1}, 32'd0);
    end
    chk("abort_no_done", saw_done, 0);

    // Reset pulse mid-frame with en held high, then restart on release
    @(posedge clk); #1;
    en_a = 1'b1;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_async_zero", {24'd0, enc0, req0, lt0, dn0, enc1, req1, lt1, dn1}, 32'd0);
    @(negedge clk);
    chk("rst_held_zero", {24'd0, enc0, req0, lt0, dn0, enc1, req1, lt1, dn1}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_restart_sof0", {24'd0, enc0, req0, lt0, dn0, enc1, req1, lt1, dn1}, 32'h88);
    en_a = 1'b0;
    @(negedge clk);
    chk("rst_restart_idle", {24'd0, enc0, req0, lt0, dn0, enc1, req1, lt1, dn1}, 32'd0);

    tx_bits = 64'h0000_0000_0000_0b5d;
    run_frame(1'b0, 12, dk, rq);
    chk("post_abort_done_k", dk, 14 * 128 - 1);
    chk("post_abort_reqs", rq, 13);

    for (int f = 0; f < 8; f++) begin
      tx_bits = {$urandom, $urandom};
      n = $urandom_range(1, 20);
      run_frame(1'b0, n, dk, rq);
      chk($sformatf("rand_a%0d_done_k", f), dk, (n + 2) * 128 - 1);
      chk($sformatf("rand_a%0d_reqs", f), rq, n + 1);
    end

    for (int f = 0; f < 20; f++) begin
      tx_bits = {$urandom, $urandom};
      n = $urandom_range(1, 40);
      run_frame(1'b1, n, dk, rq);
      chk($sformatf("rand_b%0d_done_k", f), dk, (n + 2) * 32 - 1);
      chk($sformatf("rand_b%0d_reqs", f), rq, n + 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/manchester_frame_encoder.md
MANCHESTER_FRAME_ENCODER -- requirements
Module: manchester_frame_encoder

Interface
REQ-001 Parameter BIT_TICKS, 128, clk cycles per bit period; SHALL be even and >= 8.
REQ-002 Parameter SUBCARRIER_TICKS, 16, subcarrier period in clk cycles; SHALL be even and SHALL divide BIT_TICKS/2.
REQ-003 Parameter MODULATE, 0, 0 = plain Manchester level; 1 = modulated half-bits carry the subcarrier.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 Port clk  input  1  system clock, all state on rising edge.
REQ-006 Port rst  input  1  asynchronous active-high reset.
REQ-007 Port en  input  1  frame enable; high starts and holds a frame, low aborts or returns to idle.
REQ-008 Port in_data  input  1  next bit from tx source.
REQ-009 Port in_data_valid  input  1  in_data holds a bit to send; low means no more bits.
REQ-010 Port in_req  output  1  one-cycle pulse; in_data/in_data_valid consumed on the edge ending this cycle.
REQ-011 Port encoded_data  output  1  encoded line output.
REQ-012 Port last_tick  output  1  one-cycle pulse on the final tick of every bit period (SOF, data, EOF).
REQ-013 Port done  output  1  one-cycle pulse on the final tick of EOF.

Function
REQ-014 States SHALL be IDLE, SOF, DATA, EOF, DONE; tick counter tick_cnt SHALL run 0..BIT_TICKS-1 and wrap in SOF/DATA/EOF, and SHALL be held at 0 in IDLE/DONE.
REQ-015 IDLE -> SOF on the first edge with en=1; encoded_data SHALL show SOF tick 0 in the following cycle, with one tick per cycle thereafter.
REQ-016 All outputs SHALL be registered; in_req, last_tick and done SHALL align with the tick shown on encoded_data.
REQ-017 Manchester level for bit b: ticks 0..BIT_TICKS/2-1 = b, ticks BIT_TICKS/2..BIT_TICKS-1 = !b.
REQ-018 SOF SHALL encode bit 1; EOF level SHALL be 0 for the whole period; IDLE/DONE level SHALL be 0.
REQ-019 MODULATE=0: encoded_data = level; MODULATE=1: encoded_data = level AND sc, with sc=1 when (tick_cnt mod SUBCARRIER_TICKS) < SUBCARRIER_TICKS/2, phase-locked to each bit period.
REQ-020 in_req SHALL pulse in the cycle showing tick BIT_TICKS/2 of every SOF and DATA period, and SHALL never pulse in EOF/IDLE/DONE.
REQ-021 On the in_req edge the block SHALL latch in_data into next_bit and in_data_valid into next_valid.
REQ-022 At each SOF/DATA period boundary: next_valid=1 -> DATA sending next_bit; next_valid=0 -> EOF.
REQ-023 EOF end -> DONE with a done pulse coinciding with that period's last_tick; DONE holds outputs 0 until en=0, then IDLE.
REQ-024 en=0 in any state SHALL force IDLE on the next edge, with all outputs 0 and tick_cnt 0 from the following cycle; no done pulse.
REQ-025 Frame length SHALL be (N+2)*BIT_TICKS cycles for N data bits; in_req and last_tick each SHALL have period exactly BIT_TICKS while active.
REQ-026 last_tick SHALL never assert before the first in_req of a frame.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, tick_cnt=0, next_valid=0, and in_req=last_tick=done=encoded_data=0, regardless of en.
REQ-028 After rst is released with en=1, a frame SHALL start as in REQ-015 on the first edge after release.

Verification
REQ-029 Defaults, MODULATE=0, single bit 0 -> 64 ones, 64 zeros, 64 zeros, 64 ones, then 128 zeros; done at cycle 384 after frame start.
REQ-030 MODULATE=1, single bit 1 -> SOF and data first half each 4 pulses of 8 high/8 low, second halves 0; EOF 0; done at cycle 384.
REQ-031 in_data_valid=0 at first in_req -> SOF then EOF only; done at cycle 256; exactly 1 in_req.
REQ-032 1000 random frames of 1-80 bits, both MODULATE values -> encoded stream matches the model bit-exact; in_req/last_tick period 128; in_req count = N+1.
REQ-033 en dropped at data tick 40, then rst pulsed mid-frame -> all outputs 0 on the next cycle, no done; the next frame is correct.
REQ-034 BIT_TICKS=32, SUBCARRIER_TICKS=8, bits 10 -> 16-tick halves, 4 high/4 low subcarrier, done at cycle 128.
